// File: rtl/in_cond_pkg.sv
// Shared types and defaults for input conditioning blocks.
// Used by the debouncer feeding the sequence detector.
package in_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HIGH    = 2'b10,
    S_WAIT_LO = 2'b11
  } deb_state_t;

  localparam int DEB_DEFAULT_CYCLES = 4;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for one asynchronous pin.
// Resets to 0; reusable for any level input.
module sync2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Shift the raw pin through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/in_debounce.sv
// Synchronise and debounce a raw input into a clean level.
// Adds rise/fall pulses and a saturating glitch count.
module in_debounce
  import in_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
  parameter int CNT_W           = 8,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                glitch_clr,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] HOLD_MAX =
    CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_ONE =
    CNT_W'(1);
  localparam logic [GLITCH_W-1:0] G_ONE =
    GLITCH_W'(1);

  logic w_sync2;

  deb_state_t         r_state;
  deb_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_hold;
  logic [CNT_W-1:0]   w_hold_nxt;
  logic               r_level;
  logic               w_level_nxt;
  logic               r_rise;
  logic               w_rise_nxt;
  logic               r_fall;
  logic               w_fall_nxt;
  logic               w_glitch_ev;
  logic [GLITCH_W-1:0] r_glitch;
  logic [GLITCH_W-1:0] w_glitch_nxt;

  sync2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (raw_in),
    .o_q   (w_sync2)
  );

  // Debounce FSM: next state, hold count and output pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_glitch_ev = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_sync2) begin
          w_state_nxt = S_WAIT_HI;
          w_hold_nxt  = HOLD_ONE;
        end
      end
      S_WAIT_HI: begin
        if (!w_sync2) begin
          w_state_nxt = S_LOW;
          w_hold_nxt  = '0;
          w_glitch_ev = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt = S_HIGH;
          w_hold_nxt  = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_hold_nxt  = r_hold + HOLD_ONE;
        end
      end
      S_HIGH: begin
        if (!w_sync2) begin
          w_state_nxt = S_WAIT_LO;
          w_hold_nxt  = HOLD_ONE;
        end
      end
      S_WAIT_LO: begin
        if (w_sync2) begin
          w_state_nxt = S_HIGH;
          w_hold_nxt  = '0;
          w_glitch_ev = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt = S_LOW;
          w_hold_nxt  = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_hold_nxt  = r_hold + HOLD_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_hold_nxt  = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // Glitch counter: clear wins, otherwise saturating increment.
  always_comb begin
    w_glitch_nxt = r_glitch;
    if (glitch_clr) begin
      w_glitch_nxt = '0;
    end else if (w_glitch_ev && (r_glitch != '1)) begin
      w_glitch_nxt = r_glitch + G_ONE;
    end
  end

  // Register FSM state, counters and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_LOW;
      r_hold   <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_level  <= w_level_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  assign level      = r_level;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_in_debounce.sv
// Bench for in_debounce with DEBOUNCE_CYCLES=4.
// Second instance uses a 2-bit glitch counter.
module tb_in_debounce;

  logic clk;
  logic reset;
  logic raw_in;
  logic glitch_clr;
  logic level, rise, fall;
  logic level2, rise2, fall2;
  logic [7:0] gcnt;
  logic [1:0] gcnt2;
  logic [15:0] obs;
  logic [15:0] e;
  logic [15:0] sb[$];
  int total;
  int bad;
  int g;

  in_debounce #(
    .DEBOUNCE_CYCLES(4), .CNT_W(8), .GLITCH_W(8)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .glitch_clr(glitch_clr), .level(level),
    .rise(rise), .fall(fall), .glitch_cnt(gcnt)
  );

  in_debounce #(
    .DEBOUNCE_CYCLES(4), .CNT_W(8), .GLITCH_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .glitch_clr(glitch_clr), .level(level2),
    .rise(rise2), .fall(fall2), .glitch_cnt(gcnt2)
  );

  assign obs = {level, rise, fall,
                level2, rise2, fall2, gcnt, gcnt2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(
    logic lv, logic ri, logic fa, int n);
    logic [1:0] s;
    s = (n > 3) ? 2'd3 : 2'(n);
    return {lv, ri, fa, lv, ri, fa, 8'(n), s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++;
    if (obs !== mk(0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset_async got=%h exp=%h", obs, mk(0, 0, 0, 0));
    end
    for (int k = 0; k < 6; k++) begin
      raw_in = k[0];
      sb.push_back(mk(0, 0, 0, 0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    raw_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(0, 0, 0, 0));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    g = 0;
  endtask

  task automatic test_clean_rise();
    for (int k = 0; k < 10; k++) begin
      raw_in = 1'b1;
      sb.push_back(mk(k >= 6, k == 6, 0, g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL clean_rise k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_fall_bounce();
    for (int k = 0; k < 17; k++) begin
      raw_in = (k < 2) ? 1'b0 : (k < 4) ? 1'b1 :
               (k < 6) ? 1'b0 : (k < 8) ? 1'b1 : 1'b0;
      sb.push_back(mk(k < 14, 0, k == 14,
                      g + int'(k >= 4) + int'(k >= 8)));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL fall_bounce k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    g += 2;
  endtask

  task automatic test_threshold();
    for (int k = 0; k < 10; k++) begin
      raw_in = (k < 4);
      sb.push_back(mk(0, 0, 0, g + int'(k >= 6)));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL thresh_4 k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    g += 1;
    for (int k = 0; k < 13; k++) begin
      raw_in = (k < 5);
      sb.push_back(mk(k >= 6 && k < 11, k == 6, k == 11, g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL thresh_5 k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int k = 0; k < 5; k++) begin
      raw_in = 1'b1;
      sb.push_back(mk(0, 0, 0, g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_pre k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== mk(0, 0, 0, 0)) begin
      bad++;
      $display("FAIL mid_async got=%h exp=%h", obs, mk(0, 0, 0, 0));
    end
    g = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back(mk(k >= 6, k == 6, 0, g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_relatch k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    for (int k = 0; k < 8; k++) begin
      raw_in = 1'b0;
      sb.push_back(mk(k < 6, 0, k == 6, g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_fall k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  task automatic test_sat_clear();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 6; k++) begin
        raw_in = (k == 0);
        sb.push_back(mk(0, 0, 0, g + int'(k >= 3)));
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL sat i=%0d k=%0d got=%h exp=%h", i, k, obs, e);
        end
      end
      g++;
    end
    for (int k = 0; k < 6; k++) begin
      raw_in = (k == 0);
      glitch_clr = (k == 3);
      sb.push_back(mk(0, 0, 0, (k >= 3) ? 0 : g));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL clr_win k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    glitch_clr = 1'b0;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      raw_in = (k == 0);
      sb.push_back(mk(0, 0, 0, int'(k >= 3)));
      tick();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL post_clr k=%0d got=%h exp=%h", k, obs, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    g = 0;
    reset = 1'b1;
    raw_in = 1'b0;
    glitch_clr = 1'b0;
    test_reset();
    test_clean_rise();
    test_fall_bounce();
    test_threshold();
    test_reset_mid_wait();
    test_sat_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
